// File: rtl/dot_product_vector_feeder.sv
// Buffers (t_data, weights) beats per dot product and replays each complete
// group as a gap-free compute burst followed by at least GAP_CYCLES idle cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_valid/s_ready           input beat handshake
//   s_t_data, s_weights       packed input vectors, lane 0 in LSBs
//   s_last                    final beat of the current dot product
//   compute                   registered beat valid to the dot-product unit
//   t_data, weights           registered beat payload, zero when idle
//   busy                      FSM active or FIFO non-empty
//   err_overlong              sticky: a group exceeded DEPTH beats
module dot_product_vector_feeder #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 1,
    parameter int LANES      = 8,
    parameter int EW         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [LANES*EW-1:0]   s_t_data,
    input  logic [LANES*EW-1:0]   s_weights,
    input  logic                  s_last,
    output logic                  compute,
    output logic [LANES*EW-1:0]   t_data,
    output logic [LANES*EW-1:0]   weights,
    output logic                  busy,
    output logic                  err_overlong
);

    localparam int W  = LANES * EW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } state_t;

    logic [2*W:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] grp_q, grp_d;
    logic [GW-1:0] gap_q, gap_d;
    state_t        state_q, state_d;
    logic          drop_q, drop_d;
    logic          err_q;
    logic          compute_q;
    logic [W-1:0]  tdata_q, wts_q;

    logic          acc, push, pop, overlong;
    logic [2*W:0]  head;
    logic          head_last;

    // In drop mode every beat is swallowed, so the FIFO level is irrelevant.
    assign s_ready   = ~rst & (drop_q | (cnt_q < CW'(DEPTH)));
    assign acc       = s_valid & s_ready;
    assign push      = acc & ~drop_q;
    assign head      = mem_q[rd_q];
    assign head_last = head[2*W];

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE:    pop = (grp_q != '0);
            STREAM:  pop = 1'b1;
            GAP: begin
                // Last idle cycle: IDLE picks up the next group on the
                // following edge, giving exactly GAP_CYCLES low cycles.
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            if (head_last) begin
                state_d = GAP;
                gap_d   = GW'(GAP_CYCLES - 1);
            end else begin
                state_d = STREAM;
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        grp_d    = grp_q + CW'(push & s_last) - CW'(pop & head_last);
        // A full FIFO with no complete group can never drain.
        overlong = (cnt_d == CW'(DEPTH)) && (grp_d == '0);
        drop_d   = drop_q;
        if (overlong)
            drop_d = 1'b1;
        else if (drop_q & acc & s_last)
            drop_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {s_last, s_weights, s_t_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            grp_q     <= '0;
            gap_q     <= '0;
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
            compute_q <= 1'b0;
            tdata_q   <= '0;
            wts_q     <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            grp_q   <= grp_d;
            drop_q  <= drop_d;
            if (overlong) begin
                err_q <= 1'b1;
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (push) wr_q <= wr_q + 1'b1;
                if (pop)  rd_q <= rd_q + 1'b1;
            end
            if (pop) begin
                compute_q <= 1'b1;
                tdata_q   <= head[W-1:0];
                wts_q     <= head[2*W-1:W];
            end else begin
                compute_q <= 1'b0;
                tdata_q   <= '0;
                wts_q     <= '0;
            end
        end
    end

    assign compute      = compute_q;
    assign t_data       = tdata_q;
    assign weights      = wts_q;
    assign err_overlong = err_q;
    assign busy         = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_dot_product_vector_feeder.sv
// Directed bench for dot_product_vector_feeder: latency, gap length,
// overlong-group dropping, backpressure and reset behaviour.
module tb_dot_product_vector_feeder;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic [W-1:0] s_t_data = '0;
    logic [W-1:0] s_weights = '0;

    logic         s_ready, compute, busy, err_overlong;
    logic [W-1:0] t_data, weights;
    logic         c3_s_ready, c3_compute, c3_busy, c3_err;
    logic [W-1:0] c3_t_data, c3_weights;

    dot_product_vector_feeder #(
        .DEPTH(16), .GAP_CYCLES(1), .LANES(8), .EW(8)
    ) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_t_data(s_t_data), .s_weights(s_weights), .s_last(s_last),
        .compute(compute), .t_data(t_data), .weights(weights),
        .busy(busy), .err_overlong(err_overlong)
    );

    dot_product_vector_feeder #(
        .DEPTH(16), .GAP_CYCLES(3), .LANES(8), .EW(8)
    ) u_dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(c3_s_ready),
        .s_t_data(s_t_data), .s_weights(s_weights), .s_last(s_last),
        .compute(c3_compute), .t_data(c3_t_data), .weights(c3_weights),
        .busy(c3_busy), .err_overlong(c3_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] w;
        int           c;
    } rec_t;

    rec_t q1[$];
    rec_t q3[$];
    int   zbad = 0;

    always @(negedge clk) begin
        if (compute) q1.push_back('{t_data, weights, cyc});
        else if (t_data != '0 || weights != '0) zbad++;
        if (c3_compute) q3.push_back('{c3_t_data, c3_weights, cyc});
        else if (c3_t_data != '0 || c3_weights != '0) zbad++;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] vec(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] v, input logic last);
        int n;
        n = 0;
        s_valid   = 1'b1;
        s_t_data  = vec(v);
        s_weights = vec(v ^ 8'hA5);
        s_last    = last;
        while (!s_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("push_timeout", W'(n), '0);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [7:0] v);
        if (idx < q1.size()) begin
            chk({tag, "_data"}, q1[idx].d, vec(v));
            chk({tag, "_wts"}, q1[idx].w, vec(v ^ 8'hA5));
        end else begin
            chk({tag, "_missing"}, W'(idx), W'(q1.size()));
        end
    endtask

    initial begin
        int b, b3, h, bad, mdl, pend, pushed, saw_full;

        // Reset state
        step();
        step();
        chk("rst_compute", W'(compute), '0);
        chk("rst_tdata", t_data, '0);
        chk("rst_weights", weights, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_ready", W'(s_ready), '0);
        chk("rst_err", W'(err_overlong), '0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", W'(s_ready), W'(1));

        // 3-beat group latency and ordering
        b = q1.size();
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        push(8'd3, 1'b1);
        h = cyc;
        idle(10);
        chk("t1_count", W'(q1.size() - b), W'(3));
        for (int i = 0; i < 3; i++) begin
            chk_beat("t1_beat", b + i, 8'(i + 1));
            if (b + i < q1.size())
                chk("t1_cycle", W'(q1[b+i].c), W'(h + 1 + i));
        end
        chk("t1_busy", W'(busy), '0);
        chk("t1_compute_low", W'(compute), '0);

        // Two groups, gap 1 and gap 3
        do_reset();
        b = q1.size();
        b3 = q3.size();
        push(8'd10, 1'b0);
        push(8'd11, 1'b0);
        push(8'd12, 1'b0);
        push(8'd13, 1'b1);
        h = cyc;
        push(8'd20, 1'b0);
        push(8'd21, 1'b1);
        idle(20);
        chk("t2_count", W'(q1.size() - b), W'(6));
        chk("t2_count3", W'(q3.size() - b3), W'(6));
        chk_beat("t2_b0", b, 8'd10);
        chk_beat("t2_b3", b + 3, 8'd13);
        chk_beat("t2_b4", b + 4, 8'd20);
        chk_beat("t2_b5", b + 5, 8'd21);
        if (q1.size() - b >= 6) begin
            chk("t2_start", W'(q1[b].c), W'(h + 1));
            chk("t2_run1", W'(q1[b+3].c - q1[b].c), W'(3));
            chk("t2_gap1", W'(q1[b+4].c - q1[b+3].c), W'(2));
            chk("t2_run2", W'(q1[b+5].c - q1[b+4].c), W'(1));
        end
        if (q3.size() - b3 >= 6) begin
            chk("t2_start3", W'(q3[b3].c), W'(h + 1));
            chk("t2_gap3", W'(q3[b3+4].c - q3[b3+3].c), W'(4));
            chk("t2_b4_3", q3[b3+4].d, vec(8'd20));
        end

        // 20 single-beat groups
        do_reset();
        b = q1.size();
        for (int i = 0; i < 20; i++) push(8'(100 + i), 1'b1);
        idle(60);
        chk("t3_count", W'(q1.size() - b), W'(20));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (b + i < q1.size() && q1[b+i].d != vec(8'(100 + i))) bad++;
            if (b + i + 1 < q1.size() && q1[b+i+1].c - q1[b+i].c != 2) bad++;
        end
        chk("t3_order_spacing", W'(bad), '0);

        // Overlong 20-beat group, then a normal 2-beat group
        do_reset();
        b = q1.size();
        for (int i = 0; i < 15; i++) push(8'(40 + i), 1'b0);
        chk("t4_err_before", W'(err_overlong), '0);
        push(8'd55, 1'b0);
        chk("t4_err_at16", W'(err_overlong), W'(1));
        chk("t4_ready_drop", W'(s_ready), W'(1));
        for (int i = 16; i < 20; i++) push(8'(40 + i), i == 19);
        idle(5);
        chk("t4_no_compute", W'(q1.size() - b), '0);
        push(8'd60, 1'b0);
        push(8'd61, 1'b1);
        idle(10);
        chk("t4_count", W'(q1.size() - b), W'(2));
        chk_beat("t4_b0", b, 8'd60);
        chk_beat("t4_b1", b + 1, 8'd61);
        chk("t4_err_sticky", W'(err_overlong), W'(1));
        chk("t4_busy", W'(busy), '0);

        // Backpressure: fill to 16 with single-beat groups
        do_reset();
        b = q1.size();
        mdl = 0;
        pend = 0;
        pushed = 0;
        saw_full = 0;
        for (int k = 0; k < 160; k++) begin
            mdl = mdl + pend - int'(compute);
            if (mdl == 16) saw_full = 1;
            chk("t5_ready", W'(s_ready), W'(mdl < 16));
            if (pushed < 48) begin
                s_valid   = 1'b1;
                s_last    = 1'b1;
                s_t_data  = vec(8'(128 + pushed));
                s_weights = vec(8'(128 + pushed) ^ 8'hA5);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            pend = int'(s_valid & s_ready);
            pushed += pend;
            step();
        end
        chk("t5_saw_full", W'(saw_full), W'(1));
        chk("t5_count", W'(q1.size() - b), W'(48));
        bad = 0;
        for (int i = 0; i < 48; i++)
            if (b + i < q1.size() && q1[b+i].d != vec(8'(128 + i))) bad++;
        chk("t5_order", W'(bad), '0);

        // Reset mid-stream
        do_reset();
        push(8'd70, 1'b0);
        push(8'd71, 1'b0);
        push(8'd72, 1'b0);
        push(8'd73, 1'b0);
        push(8'd74, 1'b1);
        step();
        step();
        chk("t6_streaming", W'(compute), W'(1));
        rst = 1'b1;
        #1;
        chk("t6_ready_rst", W'(s_ready), '0);
        step();
        chk("t6_compute_rst", W'(compute), '0);
        chk("t6_tdata_rst", t_data, '0);
        chk("t6_busy_rst", W'(busy), '0);
        step();
        rst = 1'b0;
        b = q1.size();
        idle(20);
        chk("t6_no_residual", W'(q1.size() - b), '0);
        chk("t6_busy_after", W'(busy), '0);

        chk("zero_when_idle", W'(zbad), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
